// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one memory bus between fetch (I) and load/store (D).
// Round-robin on ties, grant locked per transaction, watchdog on hung bus.
module rv32_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_read_in,
  input  logic [31:0] instr_address_in,
  output logic        instr_ready_out,
  output logic        instr_fault_out,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [31:0] data_address_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic        data_ready_out,
  output logic        data_fault_out,
  output logic [31:0] read_value_out,
  output logic [31:0] mem_address_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [3:0]  mem_write_mask_out,
  output logic [31:0] mem_write_value_out,
  input  logic [31:0] mem_read_value_in,
  input  logic        mem_ready_in
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT_CYCLES);

  state_t               state;
  logic                 last_grant;
  logic                 d_wr;
  logic [CNT_WIDTH-1:0] cnt;

  logic req_i, req_d;
  logic win_i, win_d;
  logic idle;
  logic sel_i, sel_d;
  logic cur_wr;
  logic timeout;
  logic done, fault;

  assign req_i = instr_read_in;
  assign req_d = data_read_in | data_write_in;

  assign win_i = req_i & (~req_d | last_grant);
  assign win_d = req_d & (~req_i | ~last_grant);

  assign idle  = (state == IDLE);
  assign sel_i = reset_n & (idle ? win_i : (state == BUSY_I));
  assign sel_d = reset_n & (idle ? win_d : (state == BUSY_D));

  // a store wins over a simultaneous load; type is latched at issue
  assign cur_wr = idle ? data_write_in : d_wr;

  assign timeout = (TIMEOUT_CYCLES != 0) && !idle && (cnt == TMO);
  assign done    = reset_n & (mem_ready_in | timeout);
  assign fault   = reset_n & timeout & ~mem_ready_in;

  assign instr_ready_out = sel_i & done;
  assign instr_fault_out = sel_i & fault;
  assign data_ready_out  = sel_d & done;
  assign data_fault_out  = sel_d & fault;

  assign read_value_out = (fault | ~reset_n) ? 32'd0 : mem_read_value_in;

  // steer the granted port onto the bus
  always_comb begin
    mem_address_out     = '0;
    mem_read_out        = 1'b0;
    mem_write_out       = 1'b0;
    mem_write_mask_out  = '0;
    mem_write_value_out = '0;
    unique case (1'b1)
      sel_i: begin
        mem_address_out = instr_address_in;
        mem_read_out    = 1'b1;
      end
      sel_d: begin
        mem_address_out = data_address_in;
        mem_write_out   = cur_wr;
        mem_read_out    = ~cur_wr;
        if (cur_wr) begin
          mem_write_mask_out  = data_write_mask_in;
          mem_write_value_out = data_write_value_in;
        end
      end
      default: ;
    endcase
  end

  // grant state, round-robin pointer and watchdog counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      d_wr       <= 1'b0;
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_i | win_d) begin
            if (win_d) d_wr <= data_write_in;
            if (mem_ready_in) begin
              last_grant <= win_d;
            end else begin
              state <= win_d ? BUSY_D : BUSY_I;
              cnt   <= CNT_WIDTH'(1);
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready_in | timeout) begin
            state      <= IDLE;
            last_grant <= (state == BUSY_D);
            cnt        <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb_rv32_mem_arbiter: directed tests for the memory arbiter.
// Three instances: watchdog 255, watchdog 4, watchdog disabled.
module tb_rv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_read;
  logic [31:0] instr_addr;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [3:0]  data_mask;
  logic [31:0] data_value;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        i_rdy_a, i_flt_a, d_rdy_a, d_flt_a;
  logic [31:0] rv_a, ma_a, mv_a;
  logic        mr_a, mw_a;
  logic [3:0]  mm_a;

  logic        i_rdy_b, i_flt_b, d_rdy_b, d_flt_b;
  logic [31:0] rv_b, ma_b, mv_b;
  logic        mr_b, mw_b;
  logic [3:0]  mm_b;

  logic        i_rdy_c, i_flt_c, d_rdy_c, d_flt_c;
  logic [31:0] rv_c, ma_c, mv_c;
  logic        mr_c, mw_c;
  logic [3:0]  mm_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv32_mem_arbiter #(.TIMEOUT_CYCLES(255), .CNT_WIDTH(8)) u_a (
    .clk(clk), .reset_n(reset_n),
    .instr_read_in(instr_read), .instr_address_in(instr_addr),
    .instr_ready_out(i_rdy_a), .instr_fault_out(i_flt_a),
    .data_read_in(data_read), .data_write_in(data_write),
    .data_address_in(data_addr), .data_write_mask_in(data_mask),
    .data_write_value_in(data_value),
    .data_ready_out(d_rdy_a), .data_fault_out(d_flt_a),
    .read_value_out(rv_a), .mem_address_out(ma_a),
    .mem_read_out(mr_a), .mem_write_out(mw_a),
    .mem_write_mask_out(mm_a), .mem_write_value_out(mv_a),
    .mem_read_value_in(mem_rdata), .mem_ready_in(mem_ready)
  );

  rv32_mem_arbiter #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) u_b (
    .clk(clk), .reset_n(reset_n),
    .instr_read_in(instr_read), .instr_address_in(instr_addr),
    .instr_ready_out(i_rdy_b), .instr_fault_out(i_flt_b),
    .data_read_in(data_read), .data_write_in(data_write),
    .data_address_in(data_addr), .data_write_mask_in(data_mask),
    .data_write_value_in(data_value),
    .data_ready_out(d_rdy_b), .data_fault_out(d_flt_b),
    .read_value_out(rv_b), .mem_address_out(ma_b),
    .mem_read_out(mr_b), .mem_write_out(mw_b),
    .mem_write_mask_out(mm_b), .mem_write_value_out(mv_b),
    .mem_read_value_in(mem_rdata), .mem_ready_in(mem_ready)
  );

  rv32_mem_arbiter #(.TIMEOUT_CYCLES(0), .CNT_WIDTH(8)) u_c (
    .clk(clk), .reset_n(reset_n),
    .instr_read_in(instr_read), .instr_address_in(instr_addr),
    .instr_ready_out(i_rdy_c), .instr_fault_out(i_flt_c),
    .data_read_in(data_read), .data_write_in(data_write),
    .data_address_in(data_addr), .data_write_mask_in(data_mask),
    .data_write_value_in(data_value),
    .data_ready_out(d_rdy_c), .data_fault_out(d_flt_c),
    .read_value_out(rv_c), .mem_address_out(ma_c),
    .mem_read_out(mr_c), .mem_write_out(mw_c),
    .mem_write_mask_out(mm_c), .mem_write_value_out(mv_c),
    .mem_read_value_in(mem_rdata), .mem_ready_in(mem_ready)
  );

  task automatic clear_inputs();
    instr_read = 1'b0;
    instr_addr = 32'h0;
    data_read  = 1'b0;
    data_write = 1'b0;
    data_addr  = 32'h0;
    data_mask  = 4'h0;
    data_value = 32'h0;
    mem_rdata  = 32'h0;
    mem_ready  = 1'b0;
  endtask

  // leaves time at posedge+1 with reset released
  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    instr_read = 1'b1;
    instr_addr = 32'h100;
    mem_ready  = 1'b1;
    mem_rdata  = 32'h55AA55AA;
    @(negedge clk);
    checks++;
    if ({mr_a, mw_a, i_rdy_a, d_rdy_a, i_flt_a, d_flt_a} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {mr_a, mw_a, i_rdy_a, d_rdy_a, i_flt_a, d_flt_a});
    end
    checks++;
    if ({ma_a, mv_a, mm_a, rv_a} !== 100'b0) begin
      failures++;
      $display("FAIL reset_bus addr=%h val=%h mask=%h rv=%h want all 0",
               ma_a, mv_a, mm_a, rv_a);
    end
    do_reset();
  endtask

  task automatic test_single_fetch();
    instr_read = 1'b1;
    instr_addr = 32'h100;
    mem_ready  = 1'b1;
    mem_rdata  = 32'h12345678;
    @(negedge clk);
    checks++;
    if ({mr_a, mw_a, i_rdy_a, d_rdy_a} !== 4'b1010) begin
      failures++;
      $display("FAIL fetch_ctrl rd/wr/irdy/drdy got=%b want=1010",
               {mr_a, mw_a, i_rdy_a, d_rdy_a});
    end
    checks++;
    if (ma_a !== 32'h100) begin
      failures++;
      $display("FAIL fetch_addr got=%h want=00000100", ma_a);
    end
    checks++;
    if (rv_a !== 32'h12345678) begin
      failures++;
      $display("FAIL fetch_rdata got=%h want=12345678", rv_a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_i;
    exp_i = 4'b0101;
    do_reset();
    instr_read = 1'b1;
    instr_addr = 32'h100;
    data_read  = 1'b1;
    data_addr  = 32'h400;
    mem_ready  = 1'b1;
    mem_rdata  = 32'hA5A5_0001;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({i_rdy_a, d_rdy_a} !== {exp_i[c], ~exp_i[c]}) begin
        failures++;
        $display("FAIL rr_grant cyc=%0d irdy/drdy got=%b want=%b",
                 c, {i_rdy_a, d_rdy_a}, {exp_i[c], ~exp_i[c]});
      end
      checks++;
      if (ma_a !== (exp_i[c] ? 32'h100 : 32'h400)) begin
        failures++;
        $display("FAIL rr_addr cyc=%0d got=%h want=%h",
                 c, ma_a, (exp_i[c] ? 32'h100 : 32'h400));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_store_hold();
    do_reset();
    instr_read = 1'b1;
    instr_addr = 32'h100;
    mem_ready  = 1'b1;
    @(posedge clk);
    #1;
    data_write = 1'b1;
    data_addr  = 32'h2000;
    data_mask  = 4'b0011;
    data_value = 32'hDEADBEEF;
    for (int c = 1; c <= 4; c++) begin
      mem_ready = (c == 4);
      @(negedge clk);
      checks++;
      if ({mw_a, mr_a, ma_a, mm_a, mv_a} !==
          {1'b1, 1'b0, 32'h2000, 4'b0011, 32'hDEADBEEF}) begin
        failures++;
        $display("FAIL store_bus cyc=%0d wr=%b rd=%b a=%h m=%b v=%h",
                 c, mw_a, mr_a, ma_a, mm_a, mv_a);
      end
      checks++;
      if ({i_rdy_a, d_rdy_a} !== {1'b0, (c == 4)}) begin
        failures++;
        $display("FAIL store_ready cyc=%0d irdy/drdy got=%b want=0%b",
                 c, {i_rdy_a, d_rdy_a}, (c == 4));
      end
      @(posedge clk);
      #1;
    end
    data_write = 1'b0;
    @(negedge clk);
    checks++;
    if ({i_rdy_a, mr_a, ma_a} !== {1'b1, 1'b1, 32'h100}) begin
      failures++;
      $display("FAIL store_next irdy=%b rd=%b a=%h want 1 1 00000100",
               i_rdy_a, mr_a, ma_a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    do_reset();
    instr_read = 1'b1;
    instr_addr = 32'h300;
    mem_rdata  = 32'hCAFEF00D;
    mem_ready  = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if ({mr_b, i_rdy_b, i_flt_b} !== {1'b1, (c == 5), (c == 5)}) begin
        failures++;
        $display("FAIL wd_pulse cyc=%0d rd/rdy/flt got=%b want=1%b%b",
                 c, {mr_b, i_rdy_b, i_flt_b}, (c == 5), (c == 5));
      end
      if (c == 5) begin
        checks++;
        if (rv_b !== 32'h0) begin
          failures++;
          $display("FAIL wd_rdata got=%h want=00000000", rv_b);
        end
      end
      @(posedge clk);
      #1;
    end
    instr_read = 1'b0;
    @(negedge clk);
    checks++;
    if ({mr_b, i_rdy_b, i_flt_b} !== 3'b000) begin
      failures++;
      $display("FAIL wd_idle rd/rdy/flt got=%b want=000",
               {mr_b, i_rdy_b, i_flt_b});
    end
    do_reset();
    instr_read = 1'b1;
    instr_addr = 32'h300;
    mem_rdata  = 32'hCAFEF00D;
    for (int c = 1; c <= 5; c++) begin
      mem_ready = (c == 5);
      @(negedge clk);
      if (c == 5) begin
        checks++;
        if ({i_rdy_b, i_flt_b, rv_b} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
          failures++;
          $display("FAIL wd_late_ok rdy=%b flt=%b rv=%h want 1 0 cafef00d",
                   i_rdy_b, i_flt_b, rv_b);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    data_read = 1'b1;
    data_addr = 32'h800;
    mem_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if ({mr_a, ma_a} !== {1'b1, 32'h800}) begin
      failures++;
      $display("FAIL mid_busy rd=%b a=%h want 1 00000800", mr_a, ma_a);
    end
    #1;
    instr_read = 1'b1;
    instr_addr = 32'h100;
    mem_ready  = 1'b1;
    reset_n    = 1'b0;
    #1;
    checks++;
    if ({mr_a, mw_a, ma_a, i_rdy_a, d_rdy_a, d_flt_a} !== 37'b0) begin
      failures++;
      $display("FAIL mid_reset rd=%b wr=%b a=%h irdy=%b drdy=%b dflt=%b",
               mr_a, mw_a, ma_a, i_rdy_a, d_rdy_a, d_flt_a);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({i_rdy_a, d_rdy_a, ma_a} !== {1'b1, 1'b0, 32'h100}) begin
      failures++;
      $display("FAIL mid_after irdy=%b drdy=%b a=%h want 1 0 00000100",
               i_rdy_a, d_rdy_a, ma_a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_no_watchdog();
    do_reset();
    instr_read = 1'b1;
    instr_addr = 32'h700;
    mem_rdata  = 32'h0BADF00D;
    mem_ready  = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      checks++;
      if ({mr_c, ma_c, i_rdy_c, i_flt_c} !== {1'b1, 32'h700, 2'b00}) begin
        failures++;
        $display("FAIL nowd_hold cyc=%0d rd=%b a=%h rdy=%b flt=%b",
                 c, mr_c, ma_c, i_rdy_c, i_flt_c);
      end
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({i_rdy_c, i_flt_c, rv_c} !== {1'b1, 1'b0, 32'h0BADF00D}) begin
      failures++;
      $display("FAIL nowd_done rdy=%b flt=%b rv=%h want 1 0 0badf00d",
               i_rdy_c, i_flt_c, rv_c);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_store_hold();
    test_timeout();
    test_reset_mid();
    test_no_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
